// File: rtl/ins_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ins_mem_pipe
// Description : Pipelined instruction memory between the fetch stage and
//               program storage. Accepts one PC per cycle on a valid/ready
//               port, returns the addressed word LATENCY cycles later through
//               a credit-bounded response FIFO, and flags misaligned,
//               out-of-range and (optionally) parity-corrupted fetches.
//               A word-write load port fills program memory at run time.
//               Optional feature macro: INS_MEM_PARITY_EN (per-word even
//               parity with an ld_perr corruption hook).
// Revision    : 1.0 - initial release
// ============================================================================
module ins_mem_pipe #(
    parameter int                WIDTH    = 32,
    parameter int                MEM_SIZE = 10,
    parameter int                LATENCY  = 1,
    parameter logic [WIDTH-1:0]  NOP_INS  = WIDTH'(32'h00000013)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_pc,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_ins,
    output logic [1:0]           rsp_err,
    input  logic                 ld_en,
    input  logic [MEM_SIZE-1:0]  ld_addr,
    input  logic [WIDTH-1:0]     ld_data,
    input  logic                 ld_perr
);

    // One credit per pipe stage plus one so a full-rate stream never stalls.
    localparam int c_CREDITS = LATENCY + 1;
    localparam int c_OCC_W   = $clog2(c_CREDITS + 1);
    localparam int c_PTR_W   = $clog2(c_CREDITS);
    localparam int c_DEPTH   = 2 ** MEM_SIZE;

    localparam logic [c_OCC_W-1:0] c_CREDITS_OCC = c_OCC_W'(c_CREDITS);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST    = c_PTR_W'(c_CREDITS - 1);

    localparam logic [1:0] c_ERR_OK    = 2'b00;
    localparam logic [1:0] c_ERR_ALIGN = 2'b01;
    localparam logic [1:0] c_ERR_RANGE = 2'b10;
    localparam logic [1:0] c_ERR_PAR   = 2'b11;

    // ------------------------------------------------------------------
    // Storage and read-side decode
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    r_mem [c_DEPTH];
    logic [MEM_SIZE-1:0] w_idx;
    logic [WIDTH-1:0]    w_rd_word;
    logic                w_misalign;
    logic                w_oor;
    logic                w_perr;
    logic [1:0]          w_rd_err;
    logic [WIDTH-1:0]    w_rd_ins;
    logic                w_accept;
    logic                w_pop;

    assign w_idx      = req_pc[MEM_SIZE+1:2];
    assign w_rd_word  = r_mem[w_idx];
    assign w_misalign = |req_pc[1:0];
    // Any address bit above the word index means the PC is past the array.
    assign w_oor      = |(req_pc >> (MEM_SIZE + 2));

    // Program memory is written by the load port only; contents are not reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

`ifdef INS_MEM_PARITY_EN
    logic r_par [c_DEPTH];

    // Even parity stored alongside each word; ld_perr deliberately corrupts it.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_par[ld_addr] <= (^ld_data) ^ ld_perr;
        end
    end

    assign w_perr = (^w_rd_word) != r_par[w_idx];
`else
    logic w_unused_perr;

    assign w_unused_perr = ld_perr;
    assign w_perr        = 1'b0;
`endif

    // Error precedence: misaligned over out-of-range over parity.
    always_comb begin
        w_rd_err = c_ERR_OK;
        if (w_misalign) begin
            w_rd_err = c_ERR_ALIGN;
        end else if (w_oor) begin
            w_rd_err = c_ERR_RANGE;
        end else if (w_perr) begin
            w_rd_err = c_ERR_PAR;
        end
    end

    assign w_rd_ins = (w_rd_err != c_ERR_OK) ? NOP_INS : w_rd_word;

    // ------------------------------------------------------------------
    // Handshakes and credit accounting
    // ------------------------------------------------------------------
    logic [c_OCC_W-1:0] r_occ;
    logic [c_OCC_W-1:0] r_cnt;

    // No pop bypass: a freed credit is visible only the cycle after the pop.
    assign req_ready = (r_occ < c_CREDITS_OCC) && !ld_en && !flush;
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = (r_cnt != '0);
    assign w_pop     = rsp_valid && rsp_ready;

    // ------------------------------------------------------------------
    // Read pipeline: the FIFO write is the final stage, so LATENCY-1
    // register stages sit between the array read and the FIFO.
    // ------------------------------------------------------------------
    logic             w_push;
    logic [WIDTH-1:0] w_push_ins;
    logic [1:0]       w_push_err;

    generate
        if (LATENCY == 1) begin : g_direct
            assign w_push     = w_accept;
            assign w_push_ins = w_rd_ins;
            assign w_push_err = w_rd_err;
        end else begin : g_pipe
            localparam int c_STAGES = LATENCY - 1;

            logic [c_STAGES-1:0] r_pv;
            logic [WIDTH-1:0]    r_pd [c_STAGES];
            logic [1:0]          r_pe [c_STAGES];

            // Shift word, error and valid toward the FIFO; flush kills valids.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pv <= '0;
                    for (int i = 0; i < c_STAGES; i++) begin
                        r_pd[i] <= '0;
                        r_pe[i] <= c_ERR_OK;
                    end
                end else begin
                    r_pv[0] <= w_accept && !flush;
                    r_pd[0] <= w_rd_ins;
                    r_pe[0] <= w_rd_err;
                    for (int i = 1; i < c_STAGES; i++) begin
                        r_pv[i] <= r_pv[i-1] && !flush;
                        r_pd[i] <= r_pd[i-1];
                        r_pe[i] <= r_pe[i-1];
                    end
                end
            end

            assign w_push     = r_pv[c_STAGES-1];
            assign w_push_ins = r_pd[c_STAGES-1];
            assign w_push_err = r_pe[c_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response FIFO, CREDITS deep; credits guarantee it never overflows.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   r_fd [c_CREDITS];
    logic [1:0]         r_fe [c_CREDITS];
    logic [c_PTR_W-1:0] r_wp;
    logic [c_PTR_W-1:0] r_rp;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // FIFO payload storage; no reset needed since output is gated by valid.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_fd[r_wp] <= w_push_ins;
            r_fe[r_wp] <= w_push_err;
        end
    end

    // Pointers, FIFO count and outstanding-request count; flush empties all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_occ <= '0;
        end else if (flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_occ <= '0;
        end else begin
            if (w_push) begin
                r_wp <= f_ptr_inc(r_wp);
            end
            if (w_pop) begin
                r_rp <= f_ptr_inc(r_rp);
            end
            r_cnt <= r_cnt + c_OCC_W'(w_push)   - c_OCC_W'(w_pop);
            r_occ <= r_occ + c_OCC_W'(w_accept) - c_OCC_W'(w_pop);
        end
    end

    assign rsp_ins = rsp_valid ? r_fd[r_rp] : '0;
    assign rsp_err = rsp_valid ? r_fe[r_rp] : c_ERR_OK;

endmodule
`default_nettype wire

// File: tb/tb_ins_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ins_mem_pipe
// Description : Self-checking bench for ins_mem_pipe. DUT A uses LATENCY=1,
//               DUT B uses LATENCY=3. Directed vector table plus hand-written
//               sequences for load ordering, latency, backpressure, flush and
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ins_mem_pipe;

    localparam logic [31:0] c_NOP = 32'h00000013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // DUT A (LATENCY=1)
    logic        a_flush, a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [31:0] a_req_pc, a_rsp_ins, a_ld_data;
    logic [1:0]  a_rsp_err;
    logic        a_ld_en, a_ld_perr;
    logic [9:0]  a_ld_addr;

    // DUT B (LATENCY=3)
    logic        b_flush, b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [31:0] b_req_pc, b_rsp_ins, b_ld_data;
    logic [1:0]  b_rsp_err;
    logic        b_ld_en, b_ld_perr;
    logic [9:0]  b_ld_addr;

    ins_mem_pipe #(.WIDTH(32), .MEM_SIZE(10), .LATENCY(1), .NOP_INS(32'h00000013)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_pc(a_req_pc),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_ins(a_rsp_ins), .rsp_err(a_rsp_err),
        .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data), .ld_perr(a_ld_perr)
    );

    ins_mem_pipe #(.WIDTH(32), .MEM_SIZE(10), .LATENCY(3), .NOP_INS(32'h00000013)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_pc(b_req_pc),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_ins(b_rsp_ins), .rsp_err(b_rsp_err),
        .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data), .ld_perr(b_ld_perr)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs [10];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [9:0] addr, input logic [31:0] data, input logic perr);
        a_ld_en = 1'b1; a_ld_addr = addr; a_ld_data = data; a_ld_perr = perr;
        step();
        a_ld_en = 1'b0; a_ld_perr = 1'b0;
    endtask

    task automatic load_b(input logic [9:0] addr, input logic [31:0] data);
        b_ld_en = 1'b1; b_ld_addr = addr; b_ld_data = data; b_ld_perr = 1'b0;
        step();
        b_ld_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        vecs[0] = '{pc: 32'h0000_0000, ins: 32'h00500113, err: 2'b00};
        vecs[1] = '{pc: 32'h0000_0004, ins: 32'h00c00193, err: 2'b00};
        vecs[2] = '{pc: 32'h0000_0006, ins: c_NOP,        err: 2'b01};
        vecs[3] = '{pc: 32'h0000_1000, ins: c_NOP,        err: 2'b10};
`ifdef INS_MEM_PARITY_EN
        vecs[4] = '{pc: 32'h0000_0008, ins: c_NOP,        err: 2'b11};
`else
        vecs[4] = '{pc: 32'h0000_0008, ins: 32'hDEADBEEF, err: 2'b00};
`endif
        vecs[5] = '{pc: 32'h0000_000C, ins: 32'h12345678, err: 2'b00};
        vecs[6] = '{pc: 32'h0000_0FFC, ins: 32'hCAFEF00D, err: 2'b00};
        vecs[7] = '{pc: 32'h0000_1002, ins: c_NOP,        err: 2'b01};
        vecs[8] = '{pc: 32'hFFFF_FFFC, ins: c_NOP,        err: 2'b10};
        vecs[9] = '{pc: 32'h0000_0001, ins: c_NOP,        err: 2'b01};

        a_flush = 0; a_req_valid = 0; a_req_pc = 0; a_rsp_ready = 0;
        a_ld_en = 0; a_ld_addr = 0; a_ld_data = 0; a_ld_perr = 0;
        b_flush = 0; b_req_valid = 0; b_req_pc = 0; b_rsp_ready = 0;
        b_ld_en = 0; b_ld_addr = 0; b_ld_data = 0; b_ld_perr = 0;

        // ---------------- reset state ----------------
        repeat (3) step();
        check("reset a_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("reset a_rsp_ins",   a_rsp_ins,        32'd0);
        check("reset a_rsp_err",   32'(a_rsp_err),   32'd0);
        check("reset b_rsp_valid", 32'(b_rsp_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post-reset a_req_ready", 32'(a_req_ready), 32'd1);
        check("post-reset b_req_ready", 32'(b_req_ready), 32'd1);

        // ---------------- program loads ----------------
        a_ld_en = 1'b1; a_ld_addr = 10'd0; a_ld_data = 32'h00500113; a_ld_perr = 1'b0;
        #1;
        check("req_ready low during load", 32'(a_req_ready), 32'd0);
        step();
        a_ld_en = 1'b0;
        load_a(10'd1,    32'h00c00193, 1'b0);
        load_a(10'd2,    32'hDEADBEEF, 1'b1);
        load_a(10'd3,    32'h12345678, 1'b0);
        load_a(10'd1023, 32'hCAFEF00D, 1'b0);
        for (int i = 0; i < 4; i++) begin
            load_b(10'(i), 32'hB000_0000 + 32'(i));
        end

        // ---------------- table-driven back-to-back fetches (LATENCY=1) ----------------
        a_rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_req_valid = 1'b1;
            a_req_pc    = vecs[i].pc;
            #1;
            check($sformatf("vec%0d req_ready", i), 32'(a_req_ready), 32'd1);
            step();
            check($sformatf("vec%0d rsp_valid", i), 32'(a_rsp_valid), 32'd1);
            check($sformatf("vec%0d rsp_ins", i),   a_rsp_ins,        vecs[i].ins);
            check($sformatf("vec%0d rsp_err", i),   32'(a_rsp_err),   32'(vecs[i].err));
        end
        a_req_valid = 1'b0;
        step();
        check("table drained a_rsp_valid", 32'(a_rsp_valid), 32'd0);

        // ---------------- load ordering: read before write sees old data ----------------
        a_req_valid = 1'b1; a_req_pc = 32'h0;
        step();
        a_ld_en = 1'b1; a_ld_addr = 10'd0; a_ld_data = 32'h11111111;
        #1;
        check("load blocks fetch", 32'(a_req_ready), 32'd0);
        check("old data rsp_ins",  a_rsp_ins,        32'h00500113);
        step();
        a_ld_en = 1'b0;
        #1;
        check("fetch after load ready", 32'(a_req_ready), 32'd1);
        step();
        a_req_valid = 1'b0;
        check("new data rsp_valid", 32'(a_rsp_valid), 32'd1);
        check("new data rsp_ins",   a_rsp_ins,        32'h11111111);
        step();

        // ---------------- latency (LATENCY=3, empty FIFO) ----------------
        b_rsp_ready = 1'b1;
        b_req_valid = 1'b1; b_req_pc = 32'h4;
        step();
        b_req_valid = 1'b0;
        check("lat t+1 rsp_valid", 32'(b_rsp_valid), 32'd0);
        step();
        check("lat t+2 rsp_valid", 32'(b_rsp_valid), 32'd0);
        step();
        check("lat t+3 rsp_valid", 32'(b_rsp_valid), 32'd1);
        check("lat t+3 rsp_ins",   b_rsp_ins,        32'hB000_0001);
        step();
        check("lat popped rsp_valid", 32'(b_rsp_valid), 32'd0);

        // ---------------- backpressure: exactly CREDITS accepts ----------------
        b_rsp_ready = 1'b0;
        b_req_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            b_req_pc = 32'(acc * 4);
            #1;
            if (b_req_ready) acc++;
            step();
        end
        b_req_valid = 1'b0;
        check("bp accepted count", 32'(acc), 32'd4);
        check("bp req_ready low",  32'(b_req_ready), 32'd0);
        check("bp head valid",     32'(b_rsp_valid), 32'd1);
        check("bp head ins",       b_rsp_ins,        32'hB000_0000);
        step();
        check("bp head stable",    b_rsp_ins,        32'hB000_0000);
        b_rsp_ready = 1'b1;
        #1;
        check("bp no pop bypass",  32'(b_req_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp drain%0d rsp_ins", k), b_rsp_ins, 32'hB000_0000 + 32'(k));
            check($sformatf("bp drain%0d rsp_err", k), 32'(b_rsp_err), 32'd0);
            step();
            if (k == 0) check("bp req_ready after first pop", 32'(b_req_ready), 32'd1);
        end
        check("bp drained rsp_valid", 32'(b_rsp_valid), 32'd0);

        // ---------------- flush with three in flight ----------------
        b_rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b_req_valid = 1'b1; b_req_pc = 32'(k * 4);
            step();
        end
        b_req_valid = 1'b0;
        b_flush = 1'b1;
        #1;
        check("flush blocks req_ready", 32'(b_req_ready), 32'd0);
        step();
        b_flush = 1'b0;
        check("flush rsp_valid next cycle", 32'(b_rsp_valid), 32'd0);
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("flush no stale c%0d", c), 32'(b_rsp_valid), 32'd0);
        end
        b_req_valid = 1'b1; b_req_pc = 32'hC;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (b_req_ready) acc++;
            step();
        end
        b_req_valid = 1'b0;
        check("flush occ cleared (accepts)", 32'(acc), 32'd4);
        check("post-flush first rsp_ins", b_rsp_ins, 32'hB000_0003);
        b_rsp_ready = 1'b1;
        repeat (6) step();
        check("post-flush drained", 32'(b_rsp_valid), 32'd0);

        // ---------------- asynchronous reset with responses buffered ----------------
        a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
        a_req_valid = 1'b1; b_req_valid = 1'b1;
        a_req_pc = 32'h0; b_req_pc = 32'h0;
        step();
        a_req_pc = 32'h4; b_req_pc = 32'h4;
        step();
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        repeat (4) step();
        check("pre-areset a buffered", 32'(a_rsp_valid), 32'd1);
        check("pre-areset b buffered", 32'(b_rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset a_rsp_valid immediate", 32'(a_rsp_valid), 32'd0);
        check("areset b_rsp_valid immediate", 32'(b_rsp_valid), 32'd0);
        check("areset a_rsp_ins immediate",   a_rsp_ins,        32'd0);
        #2;
        rst_n = 1'b1;
        step();
        check("after areset a_req_ready", 32'(a_req_ready), 32'd1);
        check("after areset b_req_ready", 32'(b_req_ready), 32'd1);
        repeat (4) step();
        check("after areset a no stale", 32'(a_rsp_valid), 32'd0);
        check("after areset b no stale", 32'(b_rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
